// File: rtl/mult_pkg.sv
// Shared definitions for the EX-stage multiplier: ALU op codes and the multiplier FSM states.
package mult_pkg;

    localparam logic [3:0] AND_OP = 4'd0;
    localparam logic [3:0] OR_OP  = 4'd1;
    localparam logic [3:0] ADD_OP = 4'd2;
    localparam logic [3:0] SLL_OP = 4'd3;
    localparam logic [3:0] SRL_OP = 4'd4;
    localparam logic [3:0] SUB_OP = 4'd6;
    localparam logic [3:0] SLT_OP = 4'd7;
    localparam logic [3:0] MUL_OP = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/mult_step.sv
// One combinational shift-add iteration: retires BITS_PER_CYCLE multiplier bits into the accumulator.
module mult_step #(
    parameter int DATA_W         = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] mcand,
    input  logic [DATA_W-1:0] mplier,
    output logic [DATA_W-1:0] acc_next,
    output logic [DATA_W-1:0] mcand_next,
    output logic [DATA_W-1:0] mplier_next
);

    logic [DATA_W-1:0] digit;

    // Only the low multiplier digit contributes this iteration; the sum wraps mod 2^DATA_W.
    assign digit       = {{(DATA_W-BITS_PER_CYCLE){1'b0}}, mplier[BITS_PER_CYCLE-1:0]};
    assign acc_next    = acc + (mcand * digit);
    assign mcand_next  = mcand << BITS_PER_CYCLE;
    assign mplier_next = mplier >> BITS_PER_CYCLE;

endmodule

// File: rtl/seq_mult_unit.sv
// Iterative shift-add multiplier for the EX stage; stalls the pipeline until the low product word is ready.
// Optional early termination when the remaining multiplier bits are zero: define MULT_EARLY_TERM_EN.
module seq_mult_unit
    import mult_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [3:0]        alu_control,
    input  logic              start,
    input  logic              flush,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              stall_o,
    output logic [DATA_W-1:0] result,
    output logic              result_valid
);

    localparam int ITER  = DATA_W / BITS_PER_CYCLE;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    mult_state_t       state;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] result_q;

    logic              is_mul;
    logic              accept;
    logic              last_iter;
    logic              done_ok;
    logic [DATA_W-1:0] acc_next;
    logic [DATA_W-1:0] mcand_next;
    logic [DATA_W-1:0] mplier_next;

    assign is_mul  = start && (alu_control == MUL_OP);
    assign accept  = (state == IDLE) && is_mul && !flush;
    assign stall_o = accept || (state == BUSY);

    mult_step #(
        .DATA_W         (DATA_W),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .acc_next    (acc_next),
        .mcand_next  (mcand_next),
        .mplier_next (mplier_next)
    );

`ifdef MULT_EARLY_TERM_EN
    assign last_iter = (count == '0) || (mplier_next == '0);
`else
    assign last_iter = (count == '0);
`endif

    // A flush arriving in DONE cancels the result: no pulse, and the previous result stays visible.
    assign done_ok      = (state == DONE) && !flush;
    assign result_valid = done_ok;
    assign result       = done_ok ? acc : result_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            count    <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= BUSY;
                        acc    <= '0;
                        mcand  <= operand_a;
                        mplier <= operand_b;
                        count  <= CNT_W'(ITER - 1);
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand_next;
                        mplier <= mplier_next;
                        if (last_iter) begin
                            state <= DONE;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!flush) begin
                        result_q <= acc;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_mult_unit.md
Name: seq_mult_unit

Overview:
- Multi-cycle iterative shift-add multiplier in the EX stage, beside the single-cycle ALU.
- Consumes the 4-bit ALU operation code produced by ALU control; code 4'd8 (MUL) engages this unit.
- Returns the low DATA_W bits of the product and stalls the pipeline through the hazard unit until the result is ready.

Parameters:
- DATA_W, 32, operand and result width.
- BITS_PER_CYCLE, 1, multiplier bits retired per iteration; legal values 1, 2, 4; must divide DATA_W.

Ports:
- clk  in  1  rising-edge clock.
- arst_n  in  1  reset, asynchronous, active-low.
- alu_control  in  4  operation code from ALU control; MUL_OP = 4'd8.
- start  in  1  ID/EX holds a valid instruction this cycle.
- flush  in  1  EX-stage flush (branch taken / exception).
- operand_a  in  DATA_W  multiplicand (rs1).
- operand_b  in  DATA_W  multiplier (rs2).
- stall_o  out  1  freeze PC, IF/ID and ID/EX.
- result  out  DATA_W  product, low DATA_W bits.
- result_valid  out  1  one-cycle pulse; result is valid this cycle.

Behaviour:
- Reset values: state IDLE; acc, mcand, mplier, count cleared to 0. Outputs on reset: stall_o 0, result 0, result_valid 0.
- ITER = DATA_W/BITS_PER_CYCLE.
- is_mul = start && (alu_control == MUL_OP).
- States: IDLE, BUSY, DONE.
- IDLE:
  - is_mul && !flush -> BUSY.
  - Load mcand=operand_a, mplier=operand_b, acc=0, count=ITER-1.
- BUSY, each cycle:
  - Add (mcand * mplier[BITS_PER_CYCLE-1:0]) to acc, mod 2^DATA_W.
  - Shift mcand left by BITS_PER_CYCLE; shift mplier right logically by BITS_PER_CYCLE.
  - count==0 -> DONE; otherwise decrement count.
- DONE:
  - result_valid=1; result=acc, which holds its value after DONE until the next accept.
  - Unconditionally -> IDLE.
  - start/is_mul are ignored in DONE, because the multiply itself is still in EX.
- stall_o = (IDLE && is_mul && !flush) || BUSY. It is combinational and must not depend on result_valid.
- Latency: accept edge, then ITER BUSY cycles, then the DONE cycle.
  - stall_o is high for ITER+1 cycles, counting the accept cycle.
  - result_valid is asserted ITER+1 cycles after the accept edge.
- Signedness: unsigned iteration. The low DATA_W bits equal the RV32M MUL result for signed operands as well.
- Boundary conditions:
  - Non-MUL alu_control: unit stays in IDLE, stall_o 0.
  - flush in BUSY or DONE -> IDLE next edge, no result_valid, result keeps its old value.
  - flush together with is_mul in IDLE: no accept.
  - arst_n low mid-operation: immediate return to reset values; the partial product is discarded.
  - Back-to-back MULs: the second is accepted in the IDLE cycle that follows DONE.
  - count wrap impossible: the transition is taken at 0.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined:
  - In BUSY, if the post-shift mplier == 0, go to DONE next edge regardless of count.
  - In IDLE, operand_b == 0 still takes exactly one BUSY cycle.
- Undefined: fixed ITER-cycle latency; early-termination logic is absent from the netlist.

Decomposition:
- Shared package mult_pkg:
  - ALU op-code constants (AND_OP 0, OR_OP 1, ADD_OP 2, SLL_OP 3, SRL_OP 4, SUB_OP 6, SLT_OP 7, MUL_OP 8), shared with ALU control and ALU.
  - FSM state enum (IDLE, BUSY, DONE).
- Sub-module mult_step:
  - Combinational single iteration: acc, mcand and mplier in; next acc, mcand and mplier out.
  - Parameterised by DATA_W and BITS_PER_CYCLE.

Test Plan:
- DATA_W=32, BITS_PER_CYCLE=1: MUL 3*5 -> stall_o high 33 cycles; result_valid pulse in cycle 33 after the accept edge; result=15.
- Operands 0xFFFFFFFF * 0x00000002 -> result 0xFFFFFFFE, matching signed -1*2. Operands 0x80000000 * 0x80000000 -> result 0.
- alu_control=ADD_OP (2) with start=1 -> stall_o 0, no state change, result_valid never asserted.
- flush at BUSY cycle 10 -> IDLE next edge, stall_o 0, no result_valid, result unchanged.
- arst_n pulsed low mid-BUSY -> all outputs 0 immediately. A subsequent 7*6 gives result 42 with normal latency.
- MULT_EARLY_TERM_EN defined: 7*3 -> result_valid 3 cycles after accept, result 21. 9*0 -> result_valid 2 cycles after accept, result 0.
